ahb_slave_sram: RTL and testbench



---
 rtl/ahb_slave_sram.sv | 162 ++++++++++++++++
 tb/tb_ahb_slave_sram.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_sram.sv
// AHB-Lite slave backed by a word-organised, byte-lane-writable memory.
// Legal transfers get an OKAY data phase with WAIT_STATES waits; illegal ones get a two-cycle ERROR.
module ahb_slave_sram #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    hsel,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [3:0]              hprot,
    input  logic                    hmastlock,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic [DATA_WIDTH/8-1:0] hwstrb,
    input  logic                    hready,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DATA_WIDTH-1:0]   hrdata
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int LSB_W = $clog2(LANES);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0]            MAX_SIZE  = 3'(LSB_W);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             hwrite_q, hwrite_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LANES-1:0] lane_q, lane_d;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [ADDR_WIDTH-1:0] size_mask;
    logic [LSB_W-1:0]      lane_low;
    logic [LANES-1:0]      lane_mask;
    logic [LANES-1:0]      byte_we;
    logic [DATA_WIDTH-1:0] rd_word;
    logic range_err, size_err, align_err, addr_err;
    logic data_done, can_accept, accept, commit;
    logic unused_inputs;

    assign unused_inputs = ^{hburst, hprot, hmastlock, htrans[0]};

    // Legality is decided entirely in the address phase so ERR1 can follow immediately.
    assign word_addr = haddr >> LSB_W;
    assign range_err = word_addr >= DEPTH_A;
    assign size_err  = hsize > MAX_SIZE;
    assign size_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
    assign align_err = (haddr & size_mask) != '0;
    assign addr_err  = range_err | size_err | align_err;
    assign lane_low  = haddr[LSB_W-1:0];

    assign data_done  = (state_q == ST_ACCESS) && (wcnt_q == 4'd0);
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_ERR2) || data_done;
    assign accept     = hsel && hready && htrans[1] && can_accept;
    assign commit     = data_done && hwrite_q;

    // One byte-wide array per lane: lane enables map straight onto RAM byte writes,
    // and the asynchronous read lets a read right after a write see the new data.
    // Contents are deliberately left out of reset.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem_q [MEM_DEPTH];

            assign lane_mask[gi] = (LSB_W'(gi) >> hsize) == (lane_low >> hsize);
            assign byte_we[gi]   = commit && lane_q[gi] && hwstrb[gi];

            always_ff @(posedge hclk) begin
                if (byte_we[gi]) begin
                    mem_q[idx_q] <= hwdata[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = mem_q[idx_q];
        end
    endgenerate

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= 4'd0;
            hwrite_q <= 1'b0;
            idx_q    <= '0;
            lane_q   <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            hwrite_q <= hwrite_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        hwrite_d = hwrite_q;
        idx_d    = idx_q;
        lane_d   = lane_q;

        case (state_q)
            ST_ACCESS: begin
                if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        // accept can only be true in a cycle that is free to take a new transfer.
        if (accept) begin
            hwrite_d = hwrite;
            idx_d    = word_addr[IDX_W-1:0];
            lane_d   = lane_mask;
            if (addr_err) begin
                state_d = ST_ERR1;
            end else begin
                state_d = ST_ACCESS;
                wcnt_d  = WAIT_INIT;
            end
        end
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        case (state_q)
            ST_ACCESS: begin
                hreadyout = (wcnt_q == 4'd0);
                if (data_done && !hwrite_q) begin
                    hrdata = rd_word;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_slave_sram.sv
// Bench for ahb_slave_sram: three instances (0, 2 and 3 wait states) driven by a pipelined
// AHB master model from a vector table, with expected responses queued in a scoreboard.
module tb_ahb_slave_sram;

    localparam int NI = 3;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    logic        stall;
    int          cur;

    logic        hsel_w      [NI];
    logic        hready_w    [NI];
    logic        hreadyout_w [NI];
    logic        hresp_w     [NI];
    logic [31:0] hrdata_w    [NI];

    always #5 hclk = ~hclk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            assign hsel_w[gi]   = (cur == gi);
            assign hready_w[gi] = hreadyout_w[gi] & ~stall;

            ahb_slave_sram #(
                .ADDR_WIDTH (32),
                .DATA_WIDTH (32),
                .MEM_DEPTH  (256),
                .WAIT_STATES(gi == 0 ? 0 : (gi == 1 ? 2 : 3))
            ) u_dut (
                .hclk     (hclk),
                .hreset   (hreset),
                .hsel     (hsel_w[gi]),
                .haddr    (haddr),
                .htrans   (htrans),
                .hwrite   (hwrite),
                .hsize    (hsize),
                .hburst   (3'b000),
                .hprot    (4'b0011),
                .hmastlock(1'b0),
                .hwdata   (hwdata),
                .hwstrb   (hwstrb),
                .hready   (hready_w[gi]),
                .hreadyout(hreadyout_w[gi]),
                .hresp    (hresp_w[gi]),
                .hrdata   (hrdata_w[gi])
            );
        end
    endgenerate

    typedef struct {
        int          k;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          stall;
    } vec_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          waits;
        int          id;
    } exp_t;

    vec_t tab[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic vec_t mk(input int k, input bit wr, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input bit err,
                                input logic [31:0] rdata, input int st);
        vec_t v;
        v.k = k; v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
        v.strb = strb; v.exp_err = err; v.exp_rdata = rdata; v.stall = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Pipelined master: the next address is presented as soon as the previous one is
    // accepted and held through wait states; called and returns at posedge+1.
    task automatic run(input int lo, input int hi);
        int   ai = lo;
        int   a_idx = 0;
        int   d_idx = 0;
        int   waits = 0;
        int   stall_left = 0;
        int   guard = 0;
        int   k;
        bit   have_a = 0;
        bit   have_d = 0;
        bit   wd_pend = 0;
        bit   rdy;
        exp_t e;
        k = tab[lo].k;
        cur = k;
        while (guard < 500) begin
            guard++;
            if (wd_pend) begin
                hwdata  = tab[d_idx].wdata;
                hwstrb  = tab[d_idx].strb;
                wd_pend = 0;
            end
            if (!have_a) begin
                if (ai <= hi) begin
                    a_idx  = ai;
                    ai++;
                    have_a = 1;
                    htrans = 2'b10;
                    haddr  = tab[a_idx].addr;
                    hwrite = tab[a_idx].wr;
                    hsize  = tab[a_idx].size;
                    stall_left = tab[a_idx].stall;
                    e.err   = tab[a_idx].exp_err;
                    e.rdata = (!tab[a_idx].wr && !tab[a_idx].exp_err) ? tab[a_idx].exp_rdata : 32'h0;
                    e.waits = tab[a_idx].exp_err ? 1 : ws_of(k);
                    e.id    = a_idx;
                    sb.push_back(e);
                end else begin
                    htrans = 2'b00;
                end
            end
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
                check($sformatf("v%0d stalled hreadyout", a_idx), 32'(hreadyout_w[k]), 32'd1);
                check($sformatf("v%0d stalled hresp", a_idx), 32'(hresp_w[k]), 32'd0);
            end else begin
                stall = 1'b0;
            end
            rdy = hreadyout_w[k] && !stall;
            if (have_d) begin
                if (rdy) begin
                    e = sb.pop_front();
                    check($sformatf("v%0d hresp", e.id), 32'(hresp_w[k]), 32'(e.err));
                    check($sformatf("v%0d wait cycles", e.id), 32'(waits), 32'(e.waits));
                    check($sformatf("v%0d hrdata", e.id), hrdata_w[k], e.rdata);
                    have_d = 0;
                end else begin
                    waits++;
                    check($sformatf("v%0d wait-cycle hresp", sb[0].id), 32'(hresp_w[k]), 32'(sb[0].err));
                end
            end
            if (rdy && have_a) begin
                d_idx   = a_idx;
                have_d  = 1;
                have_a  = 0;
                wd_pend = 1;
                waits   = 0;
            end
            if (!have_a && !have_d && ai > hi) break;
            @(posedge hclk);
            #1;
        end
        if (guard >= 500) begin
            n_checks++;
            $display("FAIL run timeout: group %0d..%0d still busy after %0d cycles, required completion", lo, hi, guard);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required $finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, b0, b1, c0, c1, d0, d1;
        hreset = 1'b1; stall = 1'b0; cur = -1;
        haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hwdata = '0; hwstrb = '0;

        // Instance 0: zero wait states
        a0 = tab.size();
        tab.push_back(mk(0, 1, 3'd2, 32'h010, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0));
        tab.push_back(mk(0, 0, 3'd2, 32'h010, 32'h0,        4'h0, 0, 32'hDEADBEEF, 0));
        tab.push_back(mk(0, 1, 3'd2, 32'h010, 32'h11223344, 4'hF, 0, 32'h0, 0));
        tab.push_back(mk(0, 1, 3'd0, 32'h013, 32'hAA000000, 4'h8, 0, 32'h0, 0));
        tab.push_back(mk(0, 0, 3'd2, 32'h010, 32'h0,        4'h0, 0, 32'hAA223344, 0));
        tab.push_back(mk(0, 1, 3'd2, 32'h020, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 0));
        tab.push_back(mk(0, 1, 3'd1, 32'h022, 32'h55660000, 4'hF, 0, 32'h0, 0));
        tab.push_back(mk(0, 1, 3'd2, 32'h020, 32'h01020304, 4'h5, 0, 32'h0, 0));
        tab.push_back(mk(0, 0, 3'd2, 32'h020, 32'h0,        4'h0, 0, 32'h5502A504, 0));
        tab.push_back(mk(0, 1, 3'd2, 32'h000, 32'h13579BDF, 4'hF, 0, 32'h0, 0));
        tab.push_back(mk(0, 1, 3'd2, 32'h400, 32'hFFFFFFFF, 4'hF, 1, 32'h0, 0));
        tab.push_back(mk(0, 0, 3'd2, 32'h000, 32'h0,        4'h0, 0, 32'h13579BDF, 0));
        tab.push_back(mk(0, 1, 3'd2, 32'h3FC, 32'h0BADF00D, 4'hF, 0, 32'h0, 0));
        tab.push_back(mk(0, 1, 3'd0, 32'h3FF, 32'h77000000, 4'h8, 0, 32'h0, 0));
        tab.push_back(mk(0, 0, 3'd2, 32'h3FC, 32'h0,        4'h0, 0, 32'h77ADF00D, 0));
        tab.push_back(mk(0, 0, 3'd2, 32'h002, 32'h0,        4'h0, 1, 32'h0, 0));
        tab.push_back(mk(0, 0, 3'd2, 32'h000, 32'h0,        4'h0, 0, 32'h13579BDF, 0));
        tab.push_back(mk(0, 0, 3'd3, 32'h010, 32'h0,        4'h0, 1, 32'h0, 0));
        tab.push_back(mk(0, 0, 3'd1, 32'h011, 32'h0,        4'h0, 1, 32'h0, 0));
        tab.push_back(mk(0, 0, 3'd1, 32'h012, 32'h0,        4'h0, 0, 32'hAA223344, 0));
        a1 = tab.size() - 1;
        // Instance 1: two wait states, first transfer held off by a stalled bus
        b0 = tab.size();
        tab.push_back(mk(1, 1, 3'd2, 32'h020, 32'hCAFEBABE, 4'hF, 0, 32'h0, 3));
        tab.push_back(mk(1, 0, 3'd2, 32'h020, 32'h0,        4'h0, 0, 32'hCAFEBABE, 0));
        tab.push_back(mk(1, 1, 3'd2, 32'h024, 32'h0000FFFF, 4'hF, 0, 32'h0, 0));
        tab.push_back(mk(1, 1, 3'd1, 32'h026, 32'h12340000, 4'hC, 0, 32'h0, 0));
        tab.push_back(mk(1, 0, 3'd2, 32'h024, 32'h0,        4'h0, 0, 32'h1234FFFF, 0));
        tab.push_back(mk(1, 1, 3'd2, 32'h404, 32'h0,        4'hF, 1, 32'h0, 0));
        tab.push_back(mk(1, 0, 3'd2, 32'h020, 32'h0,        4'h0, 0, 32'hCAFEBABE, 0));
        b1 = tab.size() - 1;
        // Instance 2: three wait states, before and after a reset mid-write
        c0 = tab.size();
        tab.push_back(mk(2, 1, 3'd2, 32'h040, 32'h11223344, 4'hF, 0, 32'h0, 0));
        tab.push_back(mk(2, 0, 3'd2, 32'h040, 32'h0,        4'h0, 0, 32'h11223344, 0));
        c1 = tab.size() - 1;
        d0 = tab.size();
        tab.push_back(mk(2, 0, 3'd2, 32'h040, 32'h0,        4'h0, 0, 32'h11223344, 0));
        d1 = tab.size() - 1;

        repeat (3) @(posedge hclk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("dut%0d reset hreadyout", k), 32'(hreadyout_w[k]), 32'd1);
            check($sformatf("dut%0d reset hresp", k), 32'(hresp_w[k]), 32'd0);
            check($sformatf("dut%0d reset hrdata", k), hrdata_w[k], 32'h0);
        end
        hreset = 1'b0;
        @(posedge hclk);
        #1;

        run(a0, a1);
        run(b0, b1);
        run(c0, c1);
        @(posedge hclk);
        #1;

        // Reset during a wait cycle of a write must drop the write and release the bus at once.
        cur = 2; haddr = 32'h040; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        @(posedge hclk);
        #1;
        htrans = 2'b00; hwdata = 32'hCAFEF00D; hwstrb = 4'hF;
        check("rst-write first wait hreadyout", 32'(hreadyout_w[2]), 32'd0);
        @(posedge hclk);
        #1;
        check("rst-write second wait hreadyout", 32'(hreadyout_w[2]), 32'd0);
        hreset = 1'b1;
        #1;
        check("async reset hreadyout", 32'(hreadyout_w[2]), 32'd1);
        check("async reset hresp", 32'(hresp_w[2]), 32'd0);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        @(posedge hclk);
        #1;
        run(d0, d1);
        @(posedge hclk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
